// File: rtl/dma_copy.sv
// dma_copy: word-copy DMA engine (bus initiator + register responder); define DMA_FILL_EN to add fill mode
module dma_copy #(
   parameter int LEN_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] address_in,
   input  logic        sel_in,
   input  logic        read_in,
   output logic [31:0] read_value_out,
   input  logic [3:0]  write_mask_in,
   input  logic [31:0] write_value_in,
   output logic        ready_out,
   output logic [31:0] address_out,
   output logic        read_out,
   output logic        write_out,
   input  logic [31:0] read_value_in,
   output logic [3:0]  write_mask_out,
   output logic [31:0] write_value_out,
   input  logic        ready_in,
   input  logic        fault_in
);
   typedef enum logic [1:0] {IDLE, RD, WR} state_t;
   state_t state_q, state_d;
   logic [31:0] src_q, dst_q, data_q, fill_val_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic done_q, fault_q, fill_q, fill_start;
   logic [2:0] wsel;
   logic reg_wr, start, last, beat_ok, unused;
   assign wsel    = address_in[4:2];
   assign reg_wr  = sel_in && (|write_mask_in) && state_q == IDLE;
   assign start   = reg_wr && wsel == 3'd3 && write_value_in[0];
   assign last    = len_q == LEN_WIDTH'(1);
   assign beat_ok = ready_in && !fault_in;
   assign ready_out = sel_in;
   assign unused  = ^{address_in[31:5], address_in[1:0], read_in};
`ifdef DMA_FILL_EN
   assign fill_start = write_value_in[3];
   // fill mode flag and fill pattern, programmable only while idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_q     <= 1'b0;
         fill_val_q <= '0;
      end else if (reg_wr) begin
         if (wsel == 3'd3) fill_q <= write_value_in[3];
         if (wsel == 3'd4) fill_val_q <= write_value_in;
      end
   end
`else
   assign fill_start = 1'b0;
   assign fill_q     = 1'b0;
   assign fill_val_q = '0;
`endif
   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else state_q <= state_d;
   end
   // next state and bus requests, all decoded from the registered state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start && len_q != '0) state_d = fill_start ? WR : RD;
         RD:   if (ready_in) state_d = fault_in ? IDLE : WR;
         WR:   if (ready_in) state_d = (fault_in || last) ? IDLE : (fill_q ? WR : RD);
         default: state_d = IDLE;
      endcase
      read_out        = state_q == RD;
      write_out       = state_q == WR;
      write_mask_out  = write_out ? 4'hF : 4'h0;
      address_out     = read_out ? src_q : (write_out ? dst_q : 32'h0);
      write_value_out = write_out ? (fill_q ? fill_val_q : data_q) : 32'h0;
   end
   // register file writes, beat bookkeeping and status flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         if (reg_wr)
            case (wsel)
               3'd0: src_q <= {write_value_in[31:2], 2'b00};
               3'd1: dst_q <= {write_value_in[31:2], 2'b00};
               3'd2: len_q <= write_value_in[LEN_WIDTH-1:0];
               3'd3: if (write_value_in[0]) begin
                  done_q  <= len_q == '0;
                  fault_q <= 1'b0;
               end
               default: ;
            endcase
         if (state_q == RD && beat_ok) data_q <= read_value_in;
         if (state_q == WR && beat_ok) begin
            if (!fill_q) src_q <= src_q + 32'd4;
            dst_q <= dst_q + 32'd4;
            len_q <= len_q - LEN_WIDTH'(1);
            if (last) done_q <= 1'b1;
         end
         if (state_q != IDLE && ready_in && fault_in) fault_q <= 1'b1;
      end
   end
   // responder read mux, live values at all times
   always_comb begin
      read_value_out = 32'h0;
      if (sel_in)
         case (wsel)
            3'd0: read_value_out = src_q;
            3'd1: read_value_out = dst_q;
            3'd2: read_value_out = 32'(len_q);
            3'd3: read_value_out = {28'h0, fill_q, fault_q, done_q, state_q != IDLE};
            3'd4: read_value_out = fill_val_q;
            default: read_value_out = 32'h0;
         endcase
   end
endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: randomized copy runs against a memory model and expected-result arithmetic
module tb_dma_copy;
   localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08, A_CTRL = 32'h0C, A_FILL = 32'h10;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [31:0] address_in = '0, read_value_out, write_value_in = '0, address_out, read_value_in = '0, write_value_out;
   logic sel_in = 0, read_in = 0, ready_out, read_out, write_out, ready_in = 0, fault_in = 0;
   logic [3:0] write_mask_in = '0, write_mask_out;
   int total = 0, bad = 0, stall_lo = 0, stall_hi = 0, rd_seen = 0, wr_seen = 0, wr_done = 0;
   logic [31:0] mem [logic [31:0]];
   int cnt, need;
   logic waiting = 0, h_rd;
   logic [31:0] h_addr;

   dma_copy dut (
      .clk(clk), .reset_n(reset_n), .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
      .read_value_out(read_value_out), .write_mask_in(write_mask_in), .write_value_in(write_value_in),
      .ready_out(ready_out), .address_out(address_out), .read_out(read_out), .write_out(write_out),
      .read_value_in(read_value_in), .write_mask_out(write_mask_out), .write_value_out(write_value_out),
      .ready_in(ready_in), .fault_in(fault_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // memory slave: random stalls, reads below 0x1000 fault, checks request stability
   always @(negedge clk) begin
      ready_in = 0;
      fault_in = 0;
      read_value_in = '0;
      if (!reset_n) waiting = 0;
      else if (read_out || write_out) begin
         if (read_out) rd_seen++;
         if (write_out) wr_seen++;
         chk("excl", {31'b0, read_out & write_out}, 32'd0);
         if (waiting) begin
            chk("hold_addr", address_out, h_addr);
            chk("hold_kind", {31'b0, read_out}, {31'b0, h_rd});
         end else begin
            waiting = 1;
            cnt = 0;
            need = $urandom_range(stall_hi, stall_lo);
            h_addr = address_out;
            h_rd = read_out;
         end
         if (cnt == need) begin
            ready_in = 1;
            waiting = 0;
            if (read_out) begin
               if (address_out < 32'h1000) fault_in = 1;
               else read_value_in = mem.exists(address_out) ? mem[address_out] : 32'h0;
            end else begin
               chk("wmask", {28'h0, write_mask_out}, 32'hF);
               mem[address_out] = write_value_out;
               wr_done++;
            end
         end else cnt++;
      end else waiting = 0;
   end

   task automatic reg_write(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      sel_in = 1;
      address_in = a;
      write_mask_in = 4'b0001 << $urandom_range(3, 0);
      write_value_in = v;
      @(posedge clk);
      #1 sel_in = 0;
      write_mask_in = '0;
   endtask

   task automatic reg_read(input logic [31:0] a, output logic [31:0] v);
      @(negedge clk);
      sel_in = 1;
      read_in = 1;
      address_in = a;
      #1 v = read_value_out;
      @(posedge clk);
      #1 sel_in = 0;
      read_in = 0;
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      int n = 0;
      do begin
         reg_read(A_CTRL, s);
         n++;
      end while (s[0] && n < 400);
      chk("timeout", {31'b0, s[0]}, 32'd0);
   endtask

   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len, input bit poke);
      logic [31:0] exp [$];
      logic [31:0] v;
      int w0;
      for (int i = 0; i < len; i++) begin
         v = $urandom;
         exp.push_back(v);
         mem[src + 32'(4 * i)] = v;
         mem[dst + 32'(4 * i)] = ~v;
      end
      reg_write(A_SRC, src | 32'($urandom_range(3, 0)));
      reg_write(A_DST, dst | 32'($urandom_range(3, 0)));
      reg_write(A_LEN, len);
      w0 = wr_done;
      reg_write(A_CTRL, 32'h1);
      @(negedge clk);
      chk("req_lat", {31'b0, read_out}, 32'd1);
      chk("first_addr", address_out, src);
      if (poke) begin
         reg_write(A_LEN, 99);
         reg_write(A_SRC, 32'h0);
         reg_write(A_CTRL, 32'h1);
         reg_read(A_CTRL, v);
         chk("busy", v, 32'h1);
      end
      wait_idle();
      reg_read(A_CTRL, v);
      chk("stat_done", v, 32'h2);
      reg_read(A_LEN, v);
      chk("len_end", v, 32'h0);
      reg_read(A_SRC, v);
      chk("src_end", v, src + 32'(4 * len));
      reg_read(A_DST, v);
      chk("dst_end", v, dst + 32'(4 * len));
      chk("nwrites", wr_done - w0, len);
      for (int i = 0; i < len; i++) chk("data", mem[dst + 32'(4 * i)], exp[i]);
   endtask

   initial begin
      logic [31:0] v;
      int w0, rs;
      bit found;
      repeat (3) @(posedge clk);
      chk("rst_rd", {31'b0, read_out}, 32'd0);
      chk("rst_wr", {31'b0, write_out}, 32'd0);
      chk("rst_addr", address_out, 32'h0);
      chk("rst_wval", write_value_out, 32'h0);
      @(negedge clk) reset_n = 1;
      reg_read(A_SRC, v); chk("rst_src", v, 32'h0);
      reg_read(A_DST, v); chk("rst_dst", v, 32'h0);
      reg_read(A_LEN, v); chk("rst_len", v, 32'h0);
      reg_read(A_CTRL, v); chk("rst_stat", v, 32'h0);
      // zero-wait copy, then stalled copy with writes attempted while busy
      run_copy(32'h1000_0000, 32'h1000_0100, 4, 0);
      stall_lo = 2; stall_hi = 2;
      run_copy(32'h1000_0000, 32'h1000_0100, 4, 1);
      stall_lo = 0; stall_hi = 0;
      // faulting first read
      reg_write(A_SRC, 32'h0);
      reg_write(A_DST, 32'h1000_0100);
      reg_write(A_LEN, 3);
      rs = wr_seen;
      reg_write(A_CTRL, 32'h1);
      wait_idle();
      reg_read(A_CTRL, v); chk("fault_stat", v, 32'h4);
      reg_read(A_LEN, v); chk("fault_len", v, 32'h3);
      reg_read(A_SRC, v); chk("fault_src", v, 32'h0);
      reg_read(A_DST, v); chk("fault_dst", v, 32'h1000_0100);
      chk("fault_nowr", wr_seen - rs, 0);
      // zero-length start
      reg_write(A_LEN, 0);
      rs = rd_seen + wr_seen;
      reg_write(A_CTRL, 32'h1);
      reg_read(A_CTRL, v); chk("len0_stat", v, 32'h2);
      repeat (3) @(negedge clk);
      chk("len0_noreq", rd_seen + wr_seen - rs, 0);
      // unimplemented addresses
      reg_write(32'h14, 32'hFFFF_FFFF);
      reg_read(32'h14, v); chk("hole14", v, 32'h0);
      reg_read(32'h1C, v); chk("hole1c", v, 32'h0);
      // destination wraps past the top of the address space
      run_copy(32'h1000_0040, 32'hFFFF_FFFC, 2, 0);
      for (int k = 0; k < 6; k++) begin
         stall_hi = $urandom_range(2, 0);
         run_copy(32'h1000_0000 + (32'($urandom_range(255, 0)) << 2),
                  32'h2000_0000 + (32'($urandom_range(255, 0)) << 2), $urandom_range(6, 1), 0);
      end
      stall_hi = 0;
`ifdef DMA_FILL_EN
      for (int i = 0; i < 5; i++) mem[32'h1000_0200 + 32'(4 * i)] = 32'h0;
      reg_write(A_FILL, 32'hDEAD_BEEF);
      reg_write(A_DST, 32'h1000_0200);
      reg_write(A_LEN, 5);
      rs = rd_seen;
      w0 = wr_done;
      reg_write(A_CTRL, 32'h9);
      wait_idle();
      reg_read(A_CTRL, v); chk("fill_stat", v, 32'hA);
      reg_read(A_FILL, v); chk("fill_reg", v, 32'hDEAD_BEEF);
      chk("fill_noread", rd_seen - rs, 0);
      chk("fill_nwr", wr_done - w0, 5);
      for (int i = 0; i < 5; i++) chk("fill_data", mem[32'h1000_0200 + 32'(4 * i)], 32'hDEAD_BEEF);
`else
      reg_write(A_FILL, 32'hDEAD_BEEF);
      reg_read(A_FILL, v); chk("nofill_reg", v, 32'h0);
      reg_write(A_LEN, 0);
      reg_write(A_CTRL, 32'h9);
      reg_read(A_CTRL, v); chk("nofill_stat", v, 32'h2);
`endif
      // reset during the write of word 2 of 8
      stall_lo = 2; stall_hi = 2;
      reg_write(A_SRC, 32'h1000_0000);
      reg_write(A_DST, 32'h1000_0300);
      reg_write(A_LEN, 8);
      w0 = wr_done;
      reg_write(A_CTRL, 32'h1);
      found = 0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         found = write_out && wr_done == w0 + 1;
      end
      chk("rst_wait", {31'b0, found}, 32'd1);
      #2 reset_n = 0;
      #1;
      chk("abort_rd", {31'b0, read_out}, 32'd0);
      chk("abort_wr", {31'b0, write_out}, 32'd0);
      chk("abort_mask", {28'h0, write_mask_out}, 32'h0);
      chk("abort_addr", address_out, 32'h0);
      chk("abort_wval", write_value_out, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1;
      reg_read(A_CTRL, v); chk("post_stat", v, 32'h0);
      reg_read(A_SRC, v); chk("post_src", v, 32'h0);
      reg_read(A_DST, v); chk("post_dst", v, 32'h0);
      reg_read(A_LEN, v); chk("post_len", v, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
